// File: rtl/string_tx_mode2.sv
// string_tx_mode2: serial stimulus transmitter for the string_detectore_mode2 link.
// Loads a WIDTH-bit word, shifts it out one bit per clock on string2, and counts
// overlapping occurrences of the 4-bit pattern string1 in the transmitted bits.
// The saturating count is reported on N_exp as the detector's reference value.
// Optional build macro STRING_TX_LSB_FIRST_EN: shift frames out LSB-first.
module string_tx_mode2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       string1,
  output logic             string2,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       N_exp
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
  localparam logic [CW-1:0] MIN_PRIOR = CW'(3);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    bitcnt_reg, bitcnt_next;
  logic [3:0]       hist_reg, hist_next;
  logic [3:0]       pat_reg, pat_next;
  logic [3:0]       match_reg, match_next;
  logic             string2_next, valid_next, busy_next, done_next;
  logic [3:0]       nexp_next;

  // Bit-order selection: first bit of a freshly loaded word, the remainder
  // left in the shift register, and the per-cycle bit/shift while sending.
  logic             load_bit, cur_bit;
  logic [WIDTH-1:0] load_rest, shifted;
  logic             tx_en, tx_bit;

`ifdef STRING_TX_LSB_FIRST_EN
  assign load_bit  = data_in[0];
  assign load_rest = data_in >> 1;
  assign cur_bit   = shift_reg[0];
  assign shifted   = shift_reg >> 1;
`else
  assign load_bit  = data_in[WIDTH-1];
  assign load_rest = data_in << 1;
  assign cur_bit   = shift_reg[WIDTH-1];
  assign shifted   = shift_reg << 1;
`endif

  // Next-state, datapath and output computation for the transmit FSM.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bitcnt_next  = bitcnt_reg;
    hist_next    = hist_reg;
    pat_next     = pat_reg;
    match_next   = match_reg;
    string2_next = 1'b0;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    nexp_next    = N_exp;
    tx_en        = 1'b0;
    tx_bit       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          // The first bit leaves on the accepting edge, so the load and the
          // first transmission happen together from cleared history/counters.
          state_next  = SEND;
          shift_next  = load_rest;
          pat_next    = string1;
          hist_next   = 4'b0000;
          bitcnt_next = '0;
          match_next  = 4'd0;
          nexp_next   = 4'd0;
          tx_en       = 1'b1;
          tx_bit      = load_bit;
        end
      end
      SEND: begin
        if (bitcnt_reg == LAST_BIT) begin
          // Every bit, including the last one's match, is already counted.
          state_next = DONE;
          done_next  = 1'b1;
          busy_next  = 1'b1;
          nexp_next  = match_reg;
        end else begin
          shift_next = shifted;
          tx_en      = 1'b1;
          tx_bit     = cur_bit;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Transmit one bit: update history and count a match once 4 bits exist.
    if (tx_en) begin
      string2_next = tx_bit;
      valid_next   = 1'b1;
      busy_next    = 1'b1;
      if ((bitcnt_next >= MIN_PRIOR) && ({hist_next[2:0], tx_bit} == pat_next) &&
          (match_next != 4'hF)) begin
        match_next = match_next + 4'd1;
      end
      hist_next   = {hist_next[2:0], tx_bit};
      bitcnt_next = bitcnt_next + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      bitcnt_reg <= '0;
      hist_reg   <= 4'b0000;
      pat_reg    <= 4'b0000;
      match_reg  <= 4'd0;
      string2    <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      N_exp      <= 4'd0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      bitcnt_reg <= bitcnt_next;
      hist_reg   <= hist_next;
      pat_reg    <= pat_next;
      match_reg  <= match_next;
      string2    <= string2_next;
      valid      <= valid_next;
      busy       <= busy_next;
      done       <= done_next;
      N_exp      <= nexp_next;
    end
  end

endmodule
